// File: rtl/rrp_arbiter_burst_if.sv
// Bundle between the per-source FWFT FIFOs, the burst arbiter and the SRAM FIFO.
// The arbiter uses the slave modport; sources and sink drive through master.
interface rrp_arbiter_burst_if #(
  parameter int unsigned WIDTH      = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
);
  logic [WIDTH-1:0]            WRITE_REQ;
  logic [WIDTH-1:0]            HOLD_REQ;
  logic [WIDTH*DATA_WIDTH-1:0] DATA_IN;
  logic [WIDTH-1:0]            READ_GRANT;
  logic                        OUT_READY;
  logic                        WRITE_OUT;
  logic [DATA_WIDTH-1:0]       DATA_OUT;
  logic [ID_WIDTH-1:0]         GRANT_ID;

  modport slave (
    input  WRITE_REQ, HOLD_REQ, DATA_IN, OUT_READY,
    output READ_GRANT, WRITE_OUT, DATA_OUT, GRANT_ID
  );

  modport master (
    output WRITE_REQ, HOLD_REQ, DATA_IN, OUT_READY,
    input  READ_GRANT, WRITE_OUT, DATA_OUT, GRANT_ID
  );
endinterface

// File: rtl/rrp_arbiter_burst.sv
// N-channel round-robin FIFO merger with burst limit, hold/preempt priority and a
// registered ready/valid output. Define ARB_CHANNEL_TAG_EN to tag DATA_OUT MSBs with the source.
module rrp_arbiter_burst #(
  parameter int unsigned WIDTH      = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned ID_WIDTH   = 4
) (
  input  logic                BUS_CLK,
  input  logic                BUS_RST,
  rrp_arbiter_burst_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned CNT_W = ($clog2(MAX_BURST + 1) < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      cur_q, cur_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [CNT_W-1:0]      burst_q, burst_d;
  logic                  wout_q, wout_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [ID_WIDTH-1:0]   gid_q, gid_d;

  logic [IDX_W-1:0]      pick;
  logic [IDX_W-1:0]      rr_j;
  logic                  found;
  logic [WIDTH-1:0]      holders;
  logic [WIDTH-1:0]      cur_oh;
  logic [WIDTH-1:0]      grant_vec;
  logic                  cur_req, cur_hold, other_hold;
  logic                  load_en, grant;
  logic [CNT_W-1:0]      burst_inc;
  logic [DATA_WIDTH-1:0] data_sel;

  // Holders win outright (lowest index); otherwise rotate from the last winner.
  always_comb begin
    holders = bus.WRITE_REQ & bus.HOLD_REQ;
    pick    = '0;
    rr_j    = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (holders[i] && !found) begin
        pick  = IDX_W'(i);
        found = 1'b1;
      end
    end
    for (int unsigned k = 1; k <= WIDTH; k++) begin
      rr_j = IDX_W'((32'(last_q) + k) % WIDTH);
      if (!found && bus.WRITE_REQ[rr_j]) begin
        pick  = rr_j;
        found = 1'b1;
      end
    end

    cur_oh         = '0;
    cur_oh[cur_q]  = 1'b1;
    cur_req        = bus.WRITE_REQ[cur_q];
    cur_hold       = bus.HOLD_REQ[cur_q];
    other_hold     = |(holders & ~cur_oh);

    load_en   = ~wout_q | bus.OUT_READY;
    grant     = (state_q == GRANT) && cur_req && load_en;
    grant_vec = grant ? cur_oh : '0;
    burst_inc = (burst_q == BURST_MAX) ? burst_q : burst_q + 1'b1;

    data_sel = bus.DATA_IN[cur_q*DATA_WIDTH +: DATA_WIDTH];
`ifdef ARB_CHANNEL_TAG_EN
    data_sel[DATA_WIDTH-1 -: ID_WIDTH] = ID_WIDTH'(cur_q);
`endif
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    burst_d = burst_q;
    wout_d  = wout_q;
    dout_d  = dout_q;
    gid_d   = gid_q;

    case (state_q)
      IDLE: begin
        if (|bus.WRITE_REQ) begin
          cur_d   = pick;
          last_d  = pick;
          burst_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Limit and preemption are only evaluated on a granted word, so a stall never ends a tenure.
        if (!cur_req) begin
          state_d = IDLE;
        end else if (grant) begin
          burst_d = burst_inc;
          if (!cur_hold && (other_hold || ((MAX_BURST != 0) && (burst_inc == BURST_MAX))))
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant) begin
      wout_d = 1'b1;
      dout_d = data_sel;
      gid_d  = ID_WIDTH'(cur_q);
    end else if (wout_q && bus.OUT_READY) begin
      wout_d = 1'b0;
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST) begin
      state_q <= IDLE;
      cur_q   <= '0;
      last_q  <= IDX_W'(WIDTH - 1);
      burst_q <= '0;
      wout_q  <= 1'b0;
      dout_q  <= '0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      wout_q  <= wout_d;
      dout_q  <= dout_d;
      gid_q   <= gid_d;
    end
  end

  assign bus.READ_GRANT = grant_vec;
  assign bus.WRITE_OUT  = wout_q;
  assign bus.DATA_OUT   = dout_q;
  assign bus.GRANT_ID   = gid_q;

endmodule
